// File: rtl/nco_loop_gear_ctrl.sv
// Carrier-recovery loop gear sequencer: forwards phase error to the NCO and switches
// the feedback shift between a wide acquisition gain and a narrow tracking gain.
module nco_loop_gear_ctrl #(
    parameter int                   ERR_WIDTH    = 16,
    parameter logic [3:0]           SHIFT_ACQ    = 4'd2,
    parameter logic [3:0]           SHIFT_TRK    = 4'd6,
    parameter logic [ERR_WIDTH-1:0] LOCK_THRESH  = 16'h0800,
    parameter int                   LOCK_COUNT   = 1024,
    parameter int                   UNLOCK_COUNT = 256
) (
    input  logic                 clk_32M768,
    input  logic                 rst_32M768,
    input  logic                 enable,
    input  logic [ERR_WIDTH-1:0] err_tdata,
    input  logic                 err_tvalid,
    input  logic                 soft_restart,
    output logic [3:0]           FEEDBACK_SHIFT,
    output logic [ERR_WIDTH-1:0] feedback_tdata,
    output logic                 feedback_tvalid,
    output logic                 locked,
    output logic [1:0]           state
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_ACQ      = 2'd1;
    localparam logic [1:0]  ST_TRK      = 2'd2;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_COUNT - 1);
    localparam logic [15:0] UNLOCK_LAST = 16'(UNLOCK_COUNT - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};

    logic [1:0]           state_reg, state_next;
    logic [15:0]          good_cnt_reg, good_cnt_next;
    logic [15:0]          bad_cnt_reg, bad_cnt_next;
    logic [3:0]           shift_reg, shift_next;
    logic                 locked_reg, locked_next;
    logic [ERR_WIDTH-1:0] fb_data_reg, fb_data_next;
    logic                 fb_valid_reg, fb_valid_next;
    logic [ERR_WIDTH-1:0] mag;
    logic                 good;

    // Most-negative input has no positive twin, so it saturates to the largest magnitude.
    always_comb begin
        mag = err_tdata;
        if (err_tdata == ERR_MIN) begin
            mag = ERR_MAX;
        end else if (err_tdata[ERR_WIDTH-1]) begin
            mag = -err_tdata;
        end
    end

    assign good = (mag < LOCK_THRESH);

    // State register: everything, outputs included, advances only on enabled cycles.
    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state_reg    <= ST_IDLE;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            shift_reg    <= SHIFT_ACQ;
            locked_reg   <= 1'b0;
            fb_data_reg  <= '0;
            fb_valid_reg <= 1'b0;
        end else if (enable) begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
            shift_reg    <= shift_next;
            locked_reg   <= locked_next;
            fb_data_reg  <= fb_data_next;
            fb_valid_reg <= fb_valid_next;
        end
    end

    // Next-state and lock/unlock scoring.
    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        if (soft_restart) begin
            state_next    = ST_IDLE;
            good_cnt_next = '0;
            bad_cnt_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_ACQ;
                    good_cnt_next = '0;
                    bad_cnt_next  = '0;
                end
                ST_ACQ: begin
                    if (err_tvalid) begin
                        if (!good) begin
                            good_cnt_next = '0;
                        end else if (good_cnt_reg == LOCK_LAST) begin
                            state_next    = ST_TRK;
                            good_cnt_next = '0;
                            bad_cnt_next  = '0;
                        end else if (good_cnt_reg != CNT_MAX) begin
                            good_cnt_next = good_cnt_reg + 16'd1;
                        end
                    end
                end
                ST_TRK: begin
                    if (err_tvalid) begin
                        if (good) begin
                            if (bad_cnt_reg != 16'd0) begin
                                bad_cnt_next = bad_cnt_reg - 16'd1;
                            end
                        end else if (bad_cnt_reg == UNLOCK_LAST) begin
                            state_next    = ST_ACQ;
                            good_cnt_next = '0;
                            bad_cnt_next  = '0;
                        end else if (bad_cnt_reg != CNT_MAX) begin
                            bad_cnt_next = bad_cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    good_cnt_next = '0;
                    bad_cnt_next  = '0;
                end
            endcase
        end
    end

    // Registered outputs follow the upcoming state so gear and lock flip with the state.
    always_comb begin
        shift_next    = (state_next == ST_TRK) ? SHIFT_TRK : SHIFT_ACQ;
        locked_next   = (state_next == ST_TRK);
        fb_valid_next = err_tvalid && (state_reg != ST_IDLE) && !soft_restart;
        fb_data_next  = err_tvalid ? err_tdata : fb_data_reg;
    end

    assign FEEDBACK_SHIFT  = shift_reg;
    assign feedback_tdata  = fb_data_reg;
    assign feedback_tvalid = fb_valid_reg;
    assign locked          = locked_reg;
    assign state           = state_reg;

endmodule

// File: tb/tb_nco_loop_gear_ctrl.sv
// Directed bench for nco_loop_gear_ctrl with short lock/unlock counts; a monitor
// compares every forwarded feedback word against a queue of expected words.
module tb_nco_loop_gear_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] err_tdata;
    logic        err_tvalid;
    logic        soft_restart;
    logic [3:0]  fb_shift;
    logic [15:0] feedback_tdata;
    logic        feedback_tvalid;
    logic        locked;
    logic [1:0]  state;

    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        mon_en;
    logic        mon_rst;

    always #5 clk = ~clk;

    nco_loop_gear_ctrl #(
        .ERR_WIDTH   (16),
        .SHIFT_ACQ   (4'd2),
        .SHIFT_TRK   (4'd6),
        .LOCK_THRESH (16'h0800),
        .LOCK_COUNT  (8),
        .UNLOCK_COUNT(4)
    ) dut (
        .clk_32M768     (clk),
        .rst_32M768     (rst),
        .enable         (enable),
        .err_tdata      (err_tdata),
        .err_tvalid     (err_tvalid),
        .soft_restart   (soft_restart),
        .FEEDBACK_SHIFT (fb_shift),
        .feedback_tdata (feedback_tdata),
        .feedback_tvalid(feedback_tvalid),
        .locked         (locked),
        .state          (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_st(input string name, input int st, input int lk, input int sh, input int tv);
        chk({name, ".state"}, state, st);
        chk({name, ".locked"}, locked, lk);
        chk({name, ".shift"}, fb_shift, sh);
        chk({name, ".tvalid"}, feedback_tvalid, tv);
    endtask

    // One enabled clock followed by one idle clock (16.384 MHz strobe).
    task automatic send(input logic [15:0] d, input logic v, input logic sr, input logic fwd);
        @(negedge clk);
        enable = 1'b1;
        err_tdata = d;
        err_tvalid = v;
        soft_restart = sr;
        if (fwd) exp_q.push_back(d);
        @(negedge clk);
        enable = 1'b0;
        err_tvalid = 1'b0;
        soft_restart = 1'b0;
        $display("txn err=%h valid=%0b restart=%0b -> state=%0d locked=%0b shift=%0d fb=%h/%0b",
                 d, v, sr, state, locked, fb_shift, feedback_tdata, feedback_tvalid);
    endtask

    // Monitor: after every enabled edge, pop and compare any presented feedback word.
    always @(posedge clk) begin
        mon_en  = enable;
        mon_rst = rst;
        #1;
        if (mon_en && !mon_rst) begin
            if (feedback_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fb_unexpected: got %h with valid=1, expected no output", feedback_tdata);
                end else begin
                    chk("fb_tdata", feedback_tdata, exp_q.pop_front());
                end
            end
            chk("fb_pending", exp_q.size(), 0);
            if (exp_q.size() != 0) exp_q.delete();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] goods[5];
        logic [15:0] bads[6];
        goods = '{16'h0100, 16'hFF00, 16'h07FF, 16'hF801, 16'h0000};
        bads  = '{16'h1000, 16'hF000, 16'h0010, 16'h7FFF, 16'h0800, 16'hF800};

        rst = 1'b1; enable = 1'b0; err_tdata = '0; err_tvalid = 1'b0; soft_restart = 1'b0;
        repeat (3) @(negedge clk);
        check_st("reset", 0, 0, 2, 0);
        chk("reset.tdata", feedback_tdata, 0);
        rst = 1'b0;

        // Leave IDLE on the first enabled edge, no data.
        send(16'h0000, 1'b0, 1'b0, 1'b0);
        check_st("t1_acq", 1, 0, 2, 0);
        send(16'h0000, 1'b0, 1'b0, 1'b0);
        check_st("t1_hold", 1, 0, 2, 0);

        // Eight good samples lock on the eighth.
        for (int i = 0; i < 8; i++) begin
            send(16'h0100 + 16'(i), 1'b1, 1'b0, 1'b1);
            if (i == 6) check_st("t2_pre", 1, 0, 2, 1);
        end
        check_st("t2_lock", 2, 1, 6, 1);

        // bad,bad,good,bad,bad,bad: net score reaches 4 on the last one.
        for (int i = 0; i < 6; i++) begin
            send(bads[i], 1'b1, 1'b0, 1'b1);
            if (i == 4) check_st("t4_pre", 2, 1, 6, 1);
        end
        check_st("t4_unlock", 1, 0, 2, 1);

        // 5 good, threshold sample (bad), 7 good: no lock; 8th good locks.
        for (int i = 0; i < 5; i++) send(goods[i], 1'b1, 1'b0, 1'b1);
        send(16'h0800, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) send(16'h0200 + 16'(i), 1'b1, 1'b0, 1'b1);
        check_st("t3_nolock", 1, 0, 2, 1);
        send(16'h0207, 1'b1, 1'b0, 1'b1);
        check_st("t3_lock", 2, 1, 6, 1);

        // Soft restart from TRACK; the IDLE-exit sample is neither forwarded nor counted.
        send(16'h0123, 1'b1, 1'b1, 1'b0);
        check_st("t5_idle", 0, 0, 2, 0);
        send(16'h0050, 1'b1, 1'b0, 1'b0);
        check_st("t5_acq", 1, 0, 2, 0);
        for (int i = 0; i < 3; i++) send(16'h0300 + 16'(i), 1'b1, 1'b0, 1'b1);
        send(16'h8000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) send(16'h0400 + 16'(i), 1'b1, 1'b0, 1'b1);
        check_st("t3_minneg", 1, 0, 2, 1);
        send(16'h0407, 1'b1, 1'b1, 1'b0);
        check_st("t5_restart_wins", 0, 0, 2, 0);
        send(16'h0408, 1'b1, 1'b1, 1'b0);
        check_st("t5_held", 0, 0, 2, 0);
        send(16'h0010, 1'b1, 1'b0, 1'b0);
        check_st("t5_reacq", 1, 0, 2, 0);
        for (int i = 0; i < 7; i++) send(16'h0500 + 16'(i), 1'b1, 1'b0, 1'b1);
        check_st("t5_full_count", 1, 0, 2, 1);
        send(16'h0507, 1'b1, 1'b0, 1'b1);
        check_st("t5_lock", 2, 1, 6, 1);

        // Freeze mid-ACQ with enable low and valid data present.
        send(16'h0000, 1'b0, 1'b1, 1'b0);
        send(16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(16'h0600 + 16'(i), 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        err_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            err_tdata = 16'h0700 + 16'(i);
            @(negedge clk);
        end
        err_tvalid = 1'b0;
        check_st("t6_frozen", 1, 0, 2, 1);
        chk("t6_frozen.tdata", feedback_tdata, 16'h0602);
        for (int i = 0; i < 4; i++) send(16'h0610 + 16'(i), 1'b1, 1'b0, 1'b1);
        check_st("t6_count_kept", 1, 0, 2, 1);
        send(16'h0614, 1'b1, 1'b0, 1'b1);
        check_st("t6_lock", 2, 1, 6, 1);

        // Reset while tracking.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_st("t6_reset", 0, 0, 2, 0);
        chk("t6_reset.tdata", feedback_tdata, 0);
        rst = 1'b0;
        send(16'h0000, 1'b0, 1'b0, 1'b0);
        check_st("t6_after_reset", 1, 0, 2, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_loop_gear_ctrl.md
Name: nco_loop_gear_ctrl

Overview:
Loop-bandwidth sequencer for the receive carrier-recovery NCO. It takes the phase-error stream from the phase detector and forwards it as the NCO feedback. It selects FEEDBACK_SHIFT: wide (acquisition) until lock is detected, then narrow (tracking). Lock/unlock detection uses error-magnitude counters. It sits between the phase detector and the NCO phase accumulator and runs in the 32.768 MHz domain under the 16.384 MHz enable strobe.

Parameters:
ERR_WIDTH, 16, width of phase-error and feedback data (signed two's complement)
SHIFT_ACQ, 4'd2, FEEDBACK_SHIFT in IDLE/ACQ (wide loop)
SHIFT_TRK, 4'd6, FEEDBACK_SHIFT in TRACK (narrow loop)
LOCK_THRESH, 16'h0800, |err| strictly below this is a "good" sample
LOCK_COUNT, 1024, consecutive good samples needed to declare lock (1..65535)
UNLOCK_COUNT, 256, net bad-sample score that declares loss of lock (1..65535)

Ports:
clk_32M768  in  1  system clock, 32.768 MHz
rst_32M768  in  1  reset, synchronous, active-high
enable  in  1  16.384 MHz clock-enable strobe; all state advances only when high
err_tdata  in  ERR_WIDTH  signed phase error from phase detector
err_tvalid  in  1  err_tdata valid (sampled only when enable=1)
soft_restart  in  1  force re-acquisition (level, sampled when enable=1)
FEEDBACK_SHIFT  out  4  loop gain shift to NCO phase block
feedback_tdata  out  ERR_WIDTH  feedback word to NCO phase block
feedback_tvalid  out  1  feedback_tdata valid
locked  out  1  loop-lock indicator
state  out  2  debug: 0 IDLE, 1 ACQ, 2 TRACK

Behaviour:
- Reset (rst_32M768=1 at clock edge, regardless of enable): state=IDLE, FEEDBACK_SHIFT=SHIFT_ACQ, feedback_tdata=0, feedback_tvalid=0, locked=0, good_cnt=0, bad_cnt=0.
- enable=0: every register holds, including outputs; inputs are ignored.
- Magnitude: mag = |err_tdata|; -2^(ERR_WIDTH-1) saturates to 2^(ERR_WIDTH-1)-1. good = mag < LOCK_THRESH (unsigned compare).
- Feedback path, per enabled cycle: feedback_tdata <= err_tdata when err_tvalid, else holds. feedback_tvalid <= err_tvalid and (state != IDLE). Latency is 1 enabled cycle.
- FEEDBACK_SHIFT and locked are registered and change on the same edge as the state register. The sample that triggers a transition is still forwarded.
- Counters are 16-bit, never wrap, and saturate at 65535.
- IDLE: counters held at 0. On the next enabled cycle -> ACQ. Samples arriving in IDLE are not forwarded and not counted.
- ACQ (shift=SHIFT_ACQ, locked=0):
  - Valid good sample: good_cnt += 1.
  - Valid bad sample: good_cnt = 0.
  - Valid good sample with good_cnt == LOCK_COUNT-1: go to TRACK, shift=SHIFT_TRK, locked=1, good_cnt=0, bad_cnt=0.
- TRACK (shift=SHIFT_TRK, locked=1):
  - Valid bad sample: bad_cnt += 1.
  - Valid good sample: bad_cnt -= 1, floor 0.
  - Valid bad sample with bad_cnt == UNLOCK_COUNT-1: go to ACQ, shift=SHIFT_ACQ, locked=0, counters cleared.
- Invalid cycles (err_tvalid=0) leave counters unchanged.
- soft_restart=1 on an enabled cycle: next state IDLE, counters cleared, locked=0, shift=SHIFT_ACQ, feedback_tvalid=0. It takes priority over simultaneous lock/unlock transitions. While held, the block stays in IDLE.
- Reset mid-operation: immediate return to reset values on the next edge. No partial counts survive.
- state encoding 3 is unreachable. If it is ever reached, the next enabled cycle goes to IDLE.

Test Plan:
1. Reset, then enable pulsed every 2nd clock, no valid data: state goes 0->1 after the first enabled edge; FEEDBACK_SHIFT=2; locked=0; feedback_tvalid=0.
2. With LOCK_COUNT=8, send 8 valid errors of 0x0100: locked rises on the edge sampling the 8th; FEEDBACK_SHIFT goes 2->6 on that same edge; state=2; each feedback_tdata equals its input, delayed 1 enabled cycle.
3. With LOCK_COUNT=8, send 5 good, then 0x0800 (boundary, counts as bad), then 7 good: no lock. An 8th good then locks. Also check err=0x8000 is treated as mag 0x7FFF, i.e. bad.
4. With UNLOCK_COUNT=4 in TRACK, send pattern bad,bad,good,bad,bad,bad: unlock on the final bad (score reaches 4); state=1; FEEDBACK_SHIFT=2; locked=0.
5. soft_restart asserted on the same enabled cycle as the lock-completing sample: state=IDLE, locked stays 0, feedback_tvalid=0. Re-acquisition needs a full LOCK_COUNT again.
6. enable held low for 10 clocks mid-ACQ with err_tvalid=1: outputs and counters frozen. Assert rst_32M768 in TRACK: all outputs return to reset values on the next clock.
